uart_tx_arbiter: RTL and testbench

//  Shares one serial UART transmit line between NREQ byte requesters.
//  - Round-robin arbitration picks the next requester.
//  - Accepts its byte over a valid/ready handshake.
//  - Serialises the byte as a standard 8N1 frame: start bit, 8 data bits LSB first, stop bit.
//  - A programmable baud divider times each bit.
//  - Sits between on-chip byte producers (debug, status, log sources) and the board txd pin.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter shared by NREQ byte sources.
// Latency: start bit drives txd on the edge after accept; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: req_ready is offered only in IDLE, so requesters simply hold valid until granted.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int IDW          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [IDW-1:0]    grant_id,
  output logic              txd,
  output logic              busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [IDW-1:0]  winner;
  logic            accept;
  logic [7:0]      win_byte;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    int idx;
    win_found = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  // One-hot ready to the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && win_found) req_ready[winner] = 1'b1;
  end

  assign accept   = |req_ready;
  assign win_byte = req_data[int'(winner)*8 +: 8];

  // Next-state logic: frame sequencing, baud timing and bit shifting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = win_byte;
          gid_d   = winner;
          busy_d  = 1'b1;
          txd_d   = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            // Next bit is what lands in shift[0] after this shift.
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          baud_d  = '0;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight and returns the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_id = gid_q;
  assign txd      = txd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, NREQ=4.
// Inputs driven on the falling edge, outputs sampled there too (ready after #1).
// Each frame is checked mid-bit against {stop, data, start}.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int CPB  = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [IDW-1:0]    grant_id;
  logic              txd;
  logic              busy;

  int  checks = 0;
  int  errors = 0;
  time last_start = 0;
  time prev_start = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .CLKS_PER_BIT(CPB), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .txd(txd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold reset for n cycles with random inputs, checking outputs each cycle.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gid", grant_id, 0);
      @(negedge clk);
      req_valid = NREQ'($urandom);
      req_data  = $urandom;
      #1;
    end
    req_valid = '0;
    req_data  = '0;
    rst_n     = 1'b1;
  endtask

  task automatic wait_ready(input int exp_idx);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_onehot", req_ready, 32'd1 << exp_idx);
  endtask

  // Follow one frame from the accept edge to the idle cycle after the stop bit.
  task automatic check_frame(input logic [7:0] data, input int exp_id,
                             input logic [NREQ-1:0] new_valid);
    logic [9:0] exp_bits;
    exp_bits = {1'b1, data, 1'b0};
    @(posedge clk);
    for (int c = 0; c < 10*CPB; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("ready_pulse", req_ready, 0);
        chk("grant_id", grant_id, exp_id);
        prev_start = last_start;
        last_start = $time;
        req_valid  = new_valid;
      end
      if (c % CPB == CPB/2) begin
        chk("txd_bit", txd, exp_bits[c/CPB]);
        chk("busy_frame", busy, 1);
      end
    end
    @(negedge clk);
    chk("idle_txd", txd, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;

    // Reset with random inputs.
    do_reset(8);

    // Single requester 1 sends 0xA5: txd 0,1,0,1,0,0,1,0,1,1.
    req_data[15:8] = 8'hA5;
    req_valid      = 4'b0010;
    wait_ready(1);
    check_frame(8'hA5, 1, 4'b0000);

    // All requesters pending: grants rotate 0,1,2,3,0 with one idle cycle between.
    do_reset(2);
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    wait_ready(0); check_frame(8'h11, 0, 4'b1111);
    wait_ready(1); check_frame(8'h22, 1, 4'b1111);
    wait_ready(2); check_frame(8'h33, 2, 4'b1111);
    wait_ready(3); check_frame(8'h44, 3, 4'b1111);
    wait_ready(0); check_frame(8'h11, 0, 4'b0000);
    // Back-to-back start bits are 10*CPB+1 cycles apart.
    chk("frame_period", 32'(last_start - prev_start), (10*CPB + 1) * 10);

    // After grants 0,1,2 only 0 and 3 remain: next grants 3 then 0.
    do_reset(2);
    req_data  = 32'h5A6B7C8D;
    req_valid = 4'b1111;
    wait_ready(0); check_frame(8'h8D, 0, 4'b1111);
    wait_ready(1); check_frame(8'h7C, 1, 4'b1111);
    wait_ready(2); check_frame(8'h6B, 2, 4'b1001);
    wait_ready(3); check_frame(8'h5A, 3, 4'b1001);
    wait_ready(0); check_frame(8'h8D, 0, 4'b0000);

    // Reset during data bit 3 aborts the frame; requester 0 is then resent cleanly.
    do_reset(2);
    req_data[7:0] = 8'hC3;
    req_valid     = 4'b0001;
    wait_ready(0);
    @(posedge clk);
    for (int c = 0; c < 18; c++) @(negedge clk);
    chk("abort_bit3", txd, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0);
    check_frame(8'hC3, 0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
